// File: rtl/odd_counter_pkg.sv
// Shared definitions for the odd counter family: checker state encoding and
// the default step/start constants used by the counter, checker and benches.
package odd_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam int ODD_STEP  = 2;
   localparam int ODD_START = 1;

endpackage : odd_counter_pkg

// File: rtl/odd_sat_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module odd_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : odd_sat_counter

// File: rtl/odd_seq_checker.sv
// Receive-side monitor for the odd-counter stream: locks onto START, START+STEP, ...
// and reports lock status, per-error pulses and a saturating error count.
module odd_seq_checker
   import odd_counter_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter int   STEP      = ODD_STEP,
   parameter logic START_LSB = 1'b1,
   parameter int   LOCK_CNT  = 4,
   parameter int   ERR_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [WIDTH-1:0] exp_o
);

   localparam int               RUN_W    = 4;
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(LOCK_CNT - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] exp_q, exp_n;
   logic [RUN_W-1:0] run_q, run_n;
   logic             err_q, err_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         exp_q <= '0;
         run_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         exp_q <= exp_n;
         run_q <= run_n;
         err_q <= err_n;
      end
   end

   // A parity violation overrides everything; otherwise the state decides
   // whether a mismatch is a silent re-seed (ACQ) or a counted break (LOCK).
   always_comb begin
      state_n = state;
      exp_n   = exp_q;
      run_n   = run_q;
      err_n   = 1'b0;
      if (valid_i) begin
         if (cnt_i[0] != START_LSB) begin
            err_n   = 1'b1;
            state_n = IDLE;
            run_n   = '0;
         end else begin
            unique case (state)
               IDLE: begin
                  exp_n   = cnt_i + STEP_W;
                  run_n   = RUN_W'(1);
                  state_n = ACQ;
               end
               ACQ: begin
                  if (cnt_i == exp_q) begin
                     exp_n = exp_q + STEP_W;
                     run_n = run_q + 1'b1;
                     if (run_q == LAST_RUN) state_n = LOCK;
                  end else begin
                     exp_n = cnt_i + STEP_W;
                     run_n = RUN_W'(1);
                  end
               end
               LOCK: begin
                  if (cnt_i == exp_q) begin
                     exp_n = exp_q + STEP_W;
                  end else begin
                     err_n   = 1'b1;
                     exp_n   = cnt_i + STEP_W;
                     run_n   = RUN_W'(1);
                     state_n = ACQ;
                  end
               end
               default: begin
                  state_n = IDLE;
                  run_n   = '0;
               end
            endcase
         end
      end
   end

   odd_sat_counter #(
      .W(ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_n),
      .count (err_cnt_o)
   );

   assign locked_o = (state == LOCK);
   assign err_o    = err_q;
   assign exp_o    = exp_q;

endmodule : odd_seq_checker

// File: doc/odd_seq_checker.md
# odd_seq_checker

Receive-side checker for the odd-counter stream. It samples an 8-bit count word each clock and locks onto the arithmetic sequence START, START+STEP, … (modulo 2^WIDTH), then flags every break in that sequence. It sits downstream of the odd counter, or any replica of it, as an in-design monitor, and reports lock status plus a saturating error count.

## Interface
Parameters:
- WIDTH, 8, width of the count word and of exp_o.
- STEP, 2, expected increment between consecutive valid samples.
- START_LSB, 1'b1, required LSB (parity) of every sample.
- LOCK_CNT, 4, consecutive in-sequence samples (seed included) needed to declare lock; legal range 2..15.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- valid_i  in  1  cnt_i carries a sample this cycle.
- cnt_i  in  WIDTH  sample from the counter.
- locked_o  out  1  checker is in LOCK.
- err_o  out  1  one-cycle pulse per detected error.
- err_cnt_o  out  ERR_W  errors since reset; saturates at all-ones.
- exp_o  out  WIDTH  value expected for the next valid sample.

## Operation
- Reset values: state IDLE, locked_o 0, err_o 0, err_cnt_o 0, exp_o 0, run counter 0.
- Cycles with valid_i=0 change nothing except the err_o default. err_o returns to 0 on every non-error edge.
- Parity error: a valid sample with cnt_i[0] != START_LSB. This is an error in every state. It pulses err_o, increments err_cnt_o, and forces the state to IDLE with run=0. exp_o keeps its value.
- IDLE: a valid sample with correct parity loads exp_o=cnt_i+STEP, sets run=1, and moves to ACQ.
- ACQ, on a valid sample:
  - Match (cnt_i==exp_o): exp_o+=STEP and run++. If run was LOCK_CNT-1, move to LOCK.
  - Mismatch with correct parity: re-seed with exp_o=cnt_i+STEP and run=1, and stay in ACQ. This is not counted as an error.
- LOCK, on a valid sample:
  - Match: exp_o+=STEP.
  - Mismatch with correct parity: pulse err_o, increment err_cnt_o, re-seed exp_o=cnt_i+STEP with run=1, and move to ACQ.
- Arithmetic: the exp_o addition is modulo 2^WIDTH, so the 8-bit default wraps 255→1. The wrap is not an error.
- err_cnt_o holds at 2^ERR_W-1. err_o still pulses after saturation.
- locked_o is registered and equals (state==LOCK).

## Timing
- A sample is consumed on the rising edge where valid_i=1.
- err_o, err_cnt_o, locked_o and exp_o reflect that sample immediately after the same edge (one-edge latency, no combinational path from inputs to outputs).
- Lock timing: a gap-free in-sequence stream starting in IDLE raises locked_o after the LOCK_CNT-th valid sample edge.
- Errors in LOCK: locked_o falls on the same edge that pulses err_o.
- Back-to-back errors produce back-to-back err_o pulses, one per sample.
- Reset mid-stream clears all state asynchronously. The first valid sample after reset deassertion is treated as an IDLE seed.

## Structure
- Shared package odd_counter_pkg holds:
  - the state enum {IDLE, ACQ, LOCK}, 2 bits;
  - default constants ODD_STEP=2 and ODD_START=1, also reused by the odd counter and its bench.
- One natural sub-module: odd_sat_counter (parameter W; inc input; saturating count output), instantiated for err_cnt_o.
- Everything else lives in one always_ff FSM plus next-state logic.

## Test plan
- Lock-up: reset, then drive 1,3,5,7 with valid_i=1. locked_o=1 after the 4th edge, exp_o=9, err_cnt_o=0.
- Wrap: while locked, drive 251,253,255,1,3. No err_o, locked_o stays 1, exp_o=5.
- Sequence break: while locked (exp_o=9), drive 13. err_o pulses once, err_cnt_o=1, locked_o=0, exp_o=15. Then drive 15,17,19: locked_o=1 again after 19.
- Parity error: drive 4 in LOCK. err_o=1, state IDLE, locked_o=0. Then drive 5,7,9,11: relock after 11.
- Gaps and saturation:
  - valid_i=0 for 10 cycles mid-stream: no state change.
  - With ERR_W=2, inject 5 parity errors: err_cnt_o sticks at 3 while err_o still pulses 5 times.
- Async reset: assert reset between edges while locked. All outputs return to 0 before the next edge. The next valid 7 seeds IDLE→ACQ with exp_o=9.
